// File: rtl/step_input_conditioner.sv
// Push-button synchronizer, debouncer and step-pulse generator with
// hold-to-auto-repeat; drives the event counter's increment enable.
module step_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  input  logic       repeat_en,
  output logic       step_pulse,
  output logic       btn_level,
  output logic [1:0] state_o
);

  localparam int DB_W =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMR_MAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W = $clog2(TMR_MAX);

  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DLY_LAST =
    TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PER_LAST =
    TMR_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_q;
  logic [DB_W-1:0]        db_cnt;
  logic                   differ;
  logic                   flip;
  logic                   rise;
  logic                   fall;

  state_t          state;
  state_t          state_d;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_d;
  logic            pulse_d;

  assign sync_q = sync_r[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], btn_in};
    end
  end

  // Level flips on the edge that completes the stable run, so the
  // FSM sees rise/fall combinationally on that same edge.
  assign differ = (sync_q != btn_level);
  assign flip   = differ && (db_cnt == DB_LAST);
  assign rise   = flip && !btn_level;
  assign fall   = flip && btn_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else if (flip) begin
      db_cnt    <= '0;
      btn_level <= ~btn_level;
    end else if (differ) begin
      db_cnt    <= db_cnt + 1'b1;
    end else begin
      db_cnt    <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      step_pulse <= 1'b0;
    end else begin
      state      <= state_d;
      timer      <= timer_d;
      step_pulse <= pulse_d;
    end
  end

  // Release outranks expiry, and a dropped repeat_en outranks expiry.
  always_comb begin
    state_d = state;
    timer_d = timer;
    pulse_d = 1'b0;
    unique case (state)
      IDLE: begin
        timer_d = '0;
        if (rise) begin
          pulse_d = 1'b1;
          state_d = HELD;
        end
      end
      HELD: begin
        if (fall) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (!repeat_en) begin
          timer_d = '0;
        end else if (timer == DLY_LAST) begin
          pulse_d = 1'b1;
          timer_d = '0;
          state_d = REPEAT;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      REPEAT: begin
        if (fall) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (!repeat_en) begin
          state_d = HELD;
          timer_d = '0;
        end else if (timer == PER_LAST) begin
          pulse_d = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_step_input_conditioner.sv
// Bench for step_input_conditioner: directed vector table, corner
// sequences, and random stimulus against a window-based model.
module tb_step_input_conditioner;

  localparam int S   = 2;
  localparam int D   = 4;
  localparam int DLY = 8;
  localparam int PER = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b0;
  logic       repeat_en = 1'b0;
  logic       step_pulse;
  logic       btn_level;
  logic [1:0] state_o;

  step_input_conditioner #(
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(DLY),
    .REPEAT_PERIOD(PER)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .repeat_en(repeat_en),
    .step_pulse(step_pulse),
    .btn_level(btn_level),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_model = 1'b0;
  logic prev_pulse = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                  name, act, exp, $time);
  endtask

  // Model: history of sampled inputs; level flips once the last D
  // synchronized samples all disagree with it.
  bit q[$];
  bit m_level;
  bit m_pressed;
  bit m_repeating;
  bit m_pulse;
  int m_since;

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < S + D; i++) q.push_back(1'b0);
    m_level     = 1'b0;
    m_pressed   = 1'b0;
    m_repeating = 1'b0;
    m_pulse     = 1'b0;
    m_since     = 0;
  endfunction

  function automatic void model_step(bit r, bit b, bit re);
    if (r) begin
      model_reset();
    end else begin
      bit win;
      int last;
      last = q.size() - 1;
      win = 1'b1;
      for (int i = 0; i < D; i++)
        if (q[last - (S - 1) - i] == m_level) win = 1'b0;
      m_pulse = 1'b0;
      if (win) begin
        m_level = !m_level;
        m_repeating = 1'b0;
        m_since = 0;
        m_pressed = m_level;
        m_pulse = m_level;
      end else if (m_pressed) begin
        if (!re) begin
          m_repeating = 1'b0;
          m_since = 0;
        end else begin
          m_since++;
          if (m_since == (m_repeating ? PER : DLY)) begin
            m_pulse = 1'b1;
            m_repeating = 1'b1;
            m_since = 0;
          end
        end
      end
      q.push_back(b);
      if (q.size() > 32) void'(q.pop_front());
    end
  endfunction

  function automatic int m_state();
    return m_pressed ? (m_repeating ? 2 : 1) : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(rst, btn_in, repeat_en);
    #1;
    if (chk_model) begin
      chk("rnd_pulse", step_pulse, m_pulse);
      chk("rnd_level", btn_level, m_level);
      chk("rnd_state", state_o, m_state());
    end
    if (prev_pulse && step_pulse)
      chk("no_double_pulse", 1, 0);
    prev_pulse = step_pulse;
  endtask

  task automatic settle(input int n);
    btn_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    int         hold;
    bit         rep;
    int         rise;
    int         fall;
    logic [63:0] pmask;
  } vec_t;

  vec_t vt[6];

  initial begin
    int lvl;
    int st;
    int npulse;
    int pat[$];

    vt[0] = '{40, 1'b0, 6, 46, 64'h40};
    vt[1] = '{30, 1'b1, 6, 36, 64'h0000_0004_4444_4040};
    vt[2] = '{3,  1'b1, 0, 0,  64'h0};
    vt[3] = '{4,  1'b0, 6, 10, 64'h40};
    vt[4] = '{10, 1'b1, 6, 16, 64'h4040};
    vt[5] = '{1,  1'b0, 0, 0,  64'h0};

    model_reset();

    // Reset with the button held down
    rst = 1'b1;
    btn_in = 1'b1;
    repeat_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_pulse", step_pulse, 0);
      chk("rst_level", btn_level, 0);
      chk("rst_state", state_o, 0);
    end
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("rst_rel_pulse@%0d", e), step_pulse, (e == 6));
    end
    settle(12);

    // Directed presses from the vector table
    for (int k = 0; k < 6; k++) begin
      rst = 1'b1;
      btn_in = 1'b0;
      repeat_en = vt[k].rep;
      tick();
      tick();
      rst = 1'b0;
      btn_in = (vt[k].hold > 0);
      for (int e = 1; e < 64; e++) begin
        tick();
        lvl = (e >= vt[k].rise && e < vt[k].fall) ? 1 : 0;
        st = (lvl == 0) ? 0 :
             (vt[k].rep && e >= vt[k].rise + DLY) ? 2 : 1;
        chk($sformatf("v%0d_pulse@%0d", k, e),
            step_pulse, vt[k].pmask[e]);
        chk($sformatf("v%0d_level@%0d", k, e), btn_level, lvl);
        chk($sformatf("v%0d_state@%0d", k, e), state_o, st);
        btn_in = (e < vt[k].hold);
      end
    end

    // Glitch train: widths 1..3 with 2-cycle gaps
    rst = 1'b1;
    btn_in = 1'b0;
    repeat_en = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int w = 1; w <= 3; w++) begin
        for (int j = 0; j < w; j++) pat.push_back(1);
        pat.push_back(0);
        pat.push_back(0);
      end
    foreach (pat[i]) begin
      btn_in = pat[i][0];
      tick();
      chk("glitch_level", btn_level, 0);
      chk("glitch_pulse", step_pulse, 0);
    end
    for (int i = 0; i < 8; i++) begin
      btn_in = 1'b0;
      tick();
      chk("glitch_tail_level", btn_level, 0);
      chk("glitch_tail_pulse", step_pulse, 0);
    end

    // Bounce for 10 cycles then hold; last rise driven after edge 10
    rst = 1'b1;
    repeat_en = 1'b0;
    tick();
    rst = 1'b0;
    btn_in = 1'b1;
    npulse = 0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      npulse += int'(step_pulse);
      chk($sformatf("bounce_pulse@%0d", e), step_pulse, (e == 16));
      btn_in = (e < 10) ? ((e % 2) == 0) : 1'b1;
    end
    chk("bounce_count", npulse, 1);
    settle(12);

    // repeat_en drops exactly on the first expiry, then returns
    rst = 1'b1;
    repeat_en = 1'b1;
    tick();
    rst = 1'b0;
    btn_in = 1'b1;
    for (int e = 1; e <= 31; e++) begin
      tick();
      chk($sformatf("rdrop_pulse@%0d", e),
          step_pulse, (e == 6 || e == 28));
      if (e >= 14 && e < 28)
        chk($sformatf("rdrop_state@%0d", e), state_o, 1);
      if (e == 28)
        chk("rdrop_state@28", state_o, 2);
      repeat_en = !(e >= 13 && e < 20);
    end
    settle(12);

    // Random stimulus against the model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_model = 1'b1;
    begin
      int run_left;
      int rst_left;
      run_left = 0;
      rst_left = 0;
      for (int i = 0; i < 3000; i++) begin
        tick();
        if (rst_left > 0) begin
          rst_left--;
          rst = (rst_left > 0);
        end else if ($urandom_range(0, 299) == 0) begin
          rst_left = $urandom_range(1, 3);
          rst = 1'b1;
        end
        if ($urandom_range(0, 39) == 0) repeat_en = ~repeat_en;
        if (run_left == 0) begin
          btn_in = ~btn_in;
          run_left = ($urandom_range(0, 3) == 0) ?
                     $urandom_range(10, 40) : $urandom_range(1, 6);
        end else begin
          run_left--;
        end
      end
    end
    chk_model = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
